// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: packs HPS loader bytes into 16-bit ROM words over a req/ack
// handshake and holds the game core in reset around every download.
module rom_load_ctrl #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned ROM_BYTES  = 32'h0004_0000,
    parameter int unsigned RESET_HOLD = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    output logic              core_reset,
    output logic              load_done
);
    localparam int unsigned WA_W  = ADDR_W - 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_FLUSH,
        S_HOLD,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic             dl_q, dl_d;
    logic [7:0]       lo_q, lo_d;
    logic [WA_W-1:0]  lo_addr_q, lo_addr_d;
    logic             lo_valid_q, lo_valid_d;
    logic [WA_W-1:0]  addr_q, addr_d;
    logic [15:0]      din_q, din_d;
    logic [1:0]       be_q, be_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_pend_q, fall_pend_d;
    logic             mem_req_q, mem_req_d;
    logic             core_reset_q, core_reset_d;
    logic             load_done_q, load_done_d;

    logic             dl_rise_c, dl_fall_c, wr_ok_c;
    logic [WA_W-1:0]  waddr_c;

    assign dl_rise_c = ioctl_download & ~dl_q;
    assign dl_fall_c = ~ioctl_download & dl_q;
    assign wr_ok_c   = ioctl_wr && (ioctl_index == 8'd0) && (32'(ioctl_addr) < ROM_BYTES);
    assign waddr_c   = ioctl_addr[ADDR_W-1:1];

    // Next-state, byte packing and registered-output decode.
    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        lo_d        = lo_q;
        lo_addr_d   = lo_addr_q;
        lo_valid_d  = lo_valid_q;
        addr_d      = addr_q;
        din_d       = din_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        fall_pend_d = fall_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (dl_rise_c) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (wr_ok_c) begin
                    if (!ioctl_addr[0]) begin
                        if (lo_valid_q) begin
                            addr_d  = lo_addr_q;
                            din_d   = {8'h00, lo_q};
                            be_d    = 2'b01;
                            state_d = S_ISSUE;
                        end
                        lo_d       = ioctl_dout;
                        lo_addr_d  = waddr_c;
                        lo_valid_d = 1'b1;
                    end else begin
                        if (lo_valid_q && (lo_addr_q == waddr_c)) begin
                            din_d      = {ioctl_dout, lo_q};
                            be_d       = 2'b11;
                            lo_valid_d = 1'b0;
                        end else begin
                            din_d = {ioctl_dout, 8'h00};
                            be_d  = 2'b10;
                        end
                        addr_d  = waddr_c;
                        state_d = S_ISSUE;
                    end
                end
                if (dl_fall_c) begin
                    if (state_d == S_ISSUE) fall_pend_d = 1'b1;
                    else if (lo_valid_d)    state_d     = S_FLUSH;
                    else                    state_d     = S_HOLD;
                end
            end
            S_ISSUE: begin
                if (dl_fall_c) fall_pend_d = 1'b1;
                if (mem_ack) begin
                    fall_pend_d = 1'b0;
                    if (fall_pend_q || dl_fall_c) state_d = lo_valid_q ? S_FLUSH : S_HOLD;
                    else                          state_d = S_COLLECT;
                end
            end
            S_FLUSH: begin
                if (mem_ack) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (dl_rise_c)          state_d = S_COLLECT;
                else if (cnt_q == '0)   state_d = S_RUN;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RUN: begin
                if (dl_rise_c) state_d = S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase

        // Entry actions shared by every path into FLUSH and HOLD.
        if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
            addr_d     = lo_addr_d;
            din_d      = {8'h00, lo_d};
            be_d       = 2'b01;
            lo_valid_d = 1'b0;
        end
        if ((state_d == S_HOLD) && (state_q != S_HOLD)) cnt_d = HOLD_INIT;
        if (dl_rise_c && ((state_q == S_HOLD) || (state_q == S_RUN))) cnt_d = '0;

        mem_req_d    = (state_d == S_ISSUE) || (state_d == S_FLUSH);
        core_reset_d = (state_d != S_RUN);
        load_done_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            lo_q         <= '0;
            lo_addr_q    <= '0;
            lo_valid_q   <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            be_q         <= '0;
            cnt_q        <= '0;
            fall_pend_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            lo_q         <= lo_d;
            lo_addr_q    <= lo_addr_d;
            lo_valid_q   <= lo_valid_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            be_q         <= be_d;
            cnt_q        <= cnt_d;
            fall_pend_q  <= fall_pend_d;
            mem_req_q    <= mem_req_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign ioctl_wait = mem_req_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_be     = be_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: expected words are queued as bytes are driven and
// popped against the writes the memory responder accepts.
module tb_rom_load_ctrl;
    localparam int unsigned RH = 255;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
    } wr_t;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        core_reset;
    logic        load_done;

    logic mon_ack   = 1'b0;
    logic stray_ack = 1'b0;
    assign mem_ack = mon_ack | stray_ack;

    wr_t sb_q[$];
    wr_t obs_q[$];
    wr_t mon_w;
    int  n_chk     = 0;
    int  n_fail    = 0;
    int  wait_bad  = 0;
    int  stall_to  = 0;
    int  ack_delay = 0;
    int  req_age   = 0;
    bit  resp_en   = 1'b1;

    rom_load_ctrl #(
        .ADDR_W     (24),
        .ROM_BYTES  (32'h0004_0000),
        .RESET_HOLD (RH)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .core_reset     (core_reset),
        .load_done      (load_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Memory responder: acks after ack_delay request cycles and logs the word.
    always @(negedge clk_sys) begin
        if (ioctl_wait !== mem_req) wait_bad++;
        if (mon_ack) begin
            mon_ack = 1'b0;
            req_age = 0;
        end else if (resp_en && (mem_req === 1'b1)) begin
            if (req_age >= ack_delay) begin
                mon_w.addr = mem_addr;
                mon_w.din  = mem_din;
                mon_w.be   = mem_be;
                obs_q.push_back(mon_w);
                mon_ack = 1'b1;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int guard = 0;
        while ((ioctl_wait === 1'b1) && (guard < 200)) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 200) stall_to++;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit timed_out);
        int guard = 0;
        while ((obs_q.size() < n) && (guard < 500)) begin
            @(negedge clk_sys);
            guard++;
        end
        timed_out = (obs_q.size() < n);
    endtask

    task automatic test_reset();
        bit saw_req = 1'b0;
        bit saw_rel = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        n_chk++;
        if ({core_reset, load_done, mem_req, ioctl_wait, mem_be} !== 6'b10_0000) begin
            n_fail++;
            $display("FAIL reset_values: got core_reset=%b load_done=%b mem_req=%b wait=%b be=%b, want 1 0 0 0 00",
                     core_reset, load_done, mem_req, ioctl_wait, mem_be);
        end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (mem_req !== 1'b0) saw_req = 1'b1;
            if ((core_reset !== 1'b1) || (load_done !== 1'b0)) saw_rel = 1'b1;
        end
        n_chk++;
        if (saw_req) begin
            n_fail++;
            $display("FAIL idle_no_req: got mem_req high while idle, want never");
        end
        n_chk++;
        if (saw_rel) begin
            n_fail++;
            $display("FAIL idle_core_reset: got core release while idle, want held");
        end
    endtask

    task automatic test_seq();
        bit  to;
        wr_t e, o;
        ack_delay = 3;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        sb_q.push_back('{addr: 23'd0, din: 16'hBBAA, be: 2'b11});
        sb_q.push_back('{addr: 23'd1, din: 16'hDDCC, be: 2'b11});
        send_byte(25'h0, 8'hAA);
        send_byte(25'h1, 8'hBB);
        n_chk++;
        if ({mem_req, ioctl_wait} !== 2'b11) begin
            n_fail++;
            $display("FAIL odd_strobe_req: got req=%b wait=%b, want 1 1", mem_req, ioctl_wait);
        end
        send_byte(25'h2, 8'hCC);
        send_byte(25'h3, 8'hDD);
        wait_obs(2, to);
        n_chk++;
        if (to) begin
            n_fail++;
            $display("FAIL seq_count: got %0d writes, want 2", obs_q.size());
        end
        while ((sb_q.size() > 0) && (obs_q.size() > 0)) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL seq_write: got %h/%h/%b, want %h/%h/%b", o.addr, o.din, o.be, e.addr, e.din, e.be);
            end
        end
        sb_q.delete();
        repeat (3) @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (RH) @(negedge clk_sys);
        n_chk++;
        if (core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_early: got core_reset=%b one cycle before release, want 1", core_reset);
        end
        @(negedge clk_sys);
        n_chk++;
        if ({core_reset, load_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release: got core_reset=%b load_done=%b, want 0 1", core_reset, load_done);
        end
    endtask

    task automatic test_odd_flush();
        bit  to;
        int  g = 0;
        wr_t e, o;
        ack_delay = 0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        n_chk++;
        if ({core_reset, load_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL rerun_reset: got core_reset=%b load_done=%b, want 1 0", core_reset, load_done);
        end
        @(negedge clk_sys);
        sb_q.push_back('{addr: 23'd0, din: 16'h2211, be: 2'b11});
        sb_q.push_back('{addr: 23'd1, din: 16'h4433, be: 2'b11});
        sb_q.push_back('{addr: 23'd2, din: 16'h0055, be: 2'b01});
        for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(8'h11 * (i + 1)));
        ioctl_download = 1'b0;
        wait_obs(3, to);
        n_chk++;
        if (to) begin
            n_fail++;
            $display("FAIL flush_count: got %0d writes, want 3", obs_q.size());
        end
        n_chk++;
        if ({core_reset, load_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_before_hold: got core_reset=%b load_done=%b, want 1 0", core_reset, load_done);
        end
        while ((sb_q.size() > 0) && (obs_q.size() > 0)) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush_write: got %h/%h/%b, want %h/%h/%b", o.addr, o.din, o.be, e.addr, e.din, e.be);
            end
        end
        sb_q.delete();
        while ((load_done !== 1'b1) && (g < 400)) begin
            @(negedge clk_sys);
            g++;
        end
        n_chk++;
        if (load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: got load_done=%b, want 1", load_done);
        end
    endtask

    task automatic test_filter();
        bit  to;
        int  g = 0;
        wr_t e, o;
        ack_delay = 1;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        send_byte(25'h10, 8'h5A);
        ioctl_index = 8'd1;
        send_byte(25'h11, 8'h77);
        ioctl_index = 8'd0;
        send_byte(25'h040001, 8'h66);
        send_byte(25'h040000, 8'h67);
        send_byte(25'h1000011, 8'h68);
        repeat (4) @(negedge clk_sys);
        n_chk++;
        if ((obs_q.size() != 0) || (mem_req !== 1'b0)) begin
            n_fail++;
            $display("FAIL filter_reject: got %0d writes req=%b, want 0 0", obs_q.size(), mem_req);
        end
        sb_q.push_back('{addr: 23'h1FFFF, din: 16'hEE00, be: 2'b10});
        sb_q.push_back('{addr: 23'h08, din: 16'hA55A, be: 2'b11});
        sb_q.push_back('{addr: 23'h19, din: 16'h0200, be: 2'b10});
        sb_q.push_back('{addr: 23'h10, din: 16'h0001, be: 2'b01});
        sb_q.push_back('{addr: 23'h11, din: 16'h0403, be: 2'b11});
        send_byte(25'h03FFFF, 8'hEE);
        send_byte(25'h11, 8'hA5);
        send_byte(25'h20, 8'h01);
        send_byte(25'h33, 8'h02);
        send_byte(25'h22, 8'h03);
        send_byte(25'h23, 8'h04);
        wait_obs(5, to);
        n_chk++;
        if (to) begin
            n_fail++;
            $display("FAIL filter_count: got %0d writes, want 5", obs_q.size());
        end
        while ((sb_q.size() > 0) && (obs_q.size() > 0)) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL filter_write: got %h/%h/%b, want %h/%h/%b", o.addr, o.din, o.be, e.addr, e.din, e.be);
            end
        end
        sb_q.delete();
        repeat (3) @(negedge clk_sys);
        ioctl_download = 1'b0;
        while ((load_done !== 1'b1) && (g < 400)) begin
            @(negedge clk_sys);
            g++;
        end
        n_chk++;
        if ((obs_q.size() != 0) || (load_done !== 1'b1)) begin
            n_fail++;
            $display("FAIL filter_end: got %0d extra writes load_done=%b, want 0 1", obs_q.size(), load_done);
        end
    endtask

    task automatic test_fall_in_issue();
        int  g = 0;
        wr_t e, o;
        ack_delay = 10;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        sb_q.push_back('{addr: 23'd0, din: 16'h3412, be: 2'b11});
        send_byte(25'h0, 8'h12);
        send_byte(25'h1, 8'h34);
        ioctl_download = 1'b0;
        while ((mem_req === 1'b1) && (g < 50)) begin
            @(negedge clk_sys);
            g++;
        end
        n_chk++;
        if ((g < 5) || (mem_req !== 1'b0) || (obs_q.size() != 1)) begin
            n_fail++;
            $display("FAIL fall_issue_done: got %0d req cycles, %0d writes, want about 10 and 1", g, obs_q.size());
        end
        while ((sb_q.size() > 0) && (obs_q.size() > 0)) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fall_issue_write: got %h/%h/%b, want %h/%h/%b", o.addr, o.din, o.be, e.addr, e.din, e.be);
            end
        end
        sb_q.delete();
        repeat (RH - 1) @(negedge clk_sys);
        n_chk++;
        if (core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_issue_early: got core_reset=%b, want 1", core_reset);
        end
        @(negedge clk_sys);
        n_chk++;
        if ({core_reset, load_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL fall_issue_release: got core_reset=%b load_done=%b, want 0 1", core_reset, load_done);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        resp_en = 1'b0;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        send_byte(25'h0, 8'h01);
        send_byte(25'h1, 8'h02);
        n_chk++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req_up: got mem_req=%b, want 1", mem_req);
        end
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        n_chk++;
        if ({mem_req, ioctl_wait, core_reset, load_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset: got req=%b wait=%b core_reset=%b done=%b, want 0 0 1 0",
                     mem_req, ioctl_wait, core_reset, load_done);
        end
        reset = 1'b0;
        @(negedge clk_sys);
        stray_ack = 1'b1;
        @(negedge clk_sys);
        stray_ack = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if ((mem_req !== 1'b0) || (core_reset !== 1'b1) || (load_done !== 1'b0)) bad = 1'b1;
        end
        n_chk++;
        if (bad || (obs_q.size() != 0)) begin
            n_fail++;
            $display("FAIL mid_idle: got activity after reset (bad=%b writes=%0d), want idle", bad, obs_q.size());
        end
        obs_q.delete();
        resp_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit  to;
        wr_t e, o;
        ack_delay = 0;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 4; i++)
            sb_q.push_back('{addr: 23'(8'h80 + i), din: {8'(2 * i + 1), 8'(2 * i)}, be: 2'b11});
        for (int i = 0; i < 8; i++) send_byte(25'(25'h100 + i), 8'(i));
        wait_obs(4, to);
        n_chk++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes, want 4", obs_q.size());
        end
        while ((sb_q.size() > 0) && (obs_q.size() > 0)) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_write: got %h/%h/%b, want %h/%h/%b", o.addr, o.din, o.be, e.addr, e.din, e.be);
            end
        end
        sb_q.delete();
        repeat (4) @(negedge clk_sys);
        ioctl_download = 1'b0;
        n_chk++;
        if (wait_bad != 0) begin
            n_fail++;
            $display("FAIL wait_tracks_req: got %0d mismatched cycles, want 0", wait_bad);
        end
        n_chk++;
        if (stall_to != 0) begin
            n_fail++;
            $display("FAIL loader_stall: got %0d stall timeouts, want 0", stall_to);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        test_reset();
        test_seq();
        test_odd_flush();
        test_filter();
        test_fall_in_issue();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
